ws2812_enc: RTL and testbench

//  WS2812 line encoder, directly downstream of the frame controller. Takes one-cycle bit strobes
//  (bit_rdy_in + bit_data_in), emits the NRZ high/low waveform on the LED data pin and returns
//  a one-cycle bit_done_out so the controller issues the next bit. The controller drives the reset
//  low time itself; this block only idles low between bits. Holds one pending bit so a

---
 rtl/ws2812_enc.sv | 124 ++++++++++++
 tb/tb_ws2812_enc.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/ws2812_enc.sv
// WS2812 NRZ line encoder with a one-deep pending bit slot.
// Turns single-cycle bit strobes into timed high/low pulses on the LED data line.
module ws2812_enc #(
    parameter logic [15:0] T0H = 16'd80,
    parameter logic [15:0] T0L = 16'd170,
    parameter logic [15:0] T1H = 16'd160,
    parameter logic [15:0] T1L = 16'd90
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic bit_rdy_in,
    input  logic bit_data_in,
    output logic bit_done_out,
    output logic busy_out,
    output logic ovf_out,
    output logic data_out
);

    typedef enum logic [1:0] {IDLE, HIGH, LOW} state_e;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        cur_q, cur_d;
    logic        pvld_q, pvld_d;
    logic        pbit_q, pbit_d;
    logic        ovf_q, ovf_d;
    logic        done_q, done_d;
    logic        busy_q, busy_d;
    logic        dout_q, dout_d;
    logic        load, load_bit, stash;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        cur_d    = cur_q;
        pvld_d   = pvld_q;
        pbit_d   = pbit_q;
        ovf_d    = ovf_q;
        load     = 1'b0;
        load_bit = 1'b0;
        stash    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bit_rdy_in) begin
                    load     = 1'b1;
                    load_bit = bit_data_in;
                end
            end
            HIGH: begin
                stash = bit_rdy_in;
                if (cnt_q == 16'd0) begin
                    state_d = LOW;
                    cnt_d   = cur_q ? T1L - 16'd1 : T0L - 16'd1;
                end else begin
                    cnt_d = cnt_q - 16'd1;
                end
            end
            LOW: begin
                if (cnt_q != 16'd0) begin
                    stash = bit_rdy_in;
                    cnt_d = cnt_q - 16'd1;
                end else if (pvld_q) begin
                    // pending bit goes first; a coincident strobe refills the slot
                    load     = 1'b1;
                    load_bit = pbit_q;
                    pvld_d   = bit_rdy_in;
                    if (bit_rdy_in) pbit_d = bit_data_in;
                end else if (bit_rdy_in) begin
                    load     = 1'b1;
                    load_bit = bit_data_in;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (stash) begin
            if (pvld_q) begin
                ovf_d = 1'b1;
            end else begin
                pvld_d = 1'b1;
                pbit_d = bit_data_in;
            end
        end
        if (load) begin
            state_d = HIGH;
            cur_d   = load_bit;
            cnt_d   = load_bit ? T1H - 16'd1 : T0H - 16'd1;
        end
        dout_d = (state_d == HIGH);
        done_d = (state_d == LOW) && (cnt_d == 16'd0);
        busy_d = (state_d != IDLE) || pvld_d;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q <= IDLE;
            cnt_q   <= 16'd0;
            cur_q   <= 1'b0;
            pvld_q  <= 1'b0;
            pbit_q  <= 1'b0;
            ovf_q   <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cur_q   <= cur_d;
            pvld_q  <= pvld_d;
            pbit_q  <= pbit_d;
            ovf_q   <= ovf_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            dout_q  <= dout_d;
        end
    end

    assign bit_done_out = done_q;
    assign busy_out     = busy_q;
    assign ovf_out      = ovf_q;
    assign data_out     = dout_q;

endmodule

// File: tb/tb_ws2812_enc.sv
// Directed bench for ws2812_enc: vector table of strobe patterns
// plus hand-written reset-mid-bit and closed-loop frame sequences.
module tb_ws2812_enc;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rdy = 1'b0;
    logic din = 1'b0;
    logic done, busy, ovf, dout;

    int nchk = 0;
    int nerr = 0;

    ws2812_enc dut (
        .clk_in      (clk),
        .rst_in      (rst),
        .bit_rdy_in  (rdy),
        .bit_data_in (din),
        .bit_done_out(done),
        .busy_out    (busy),
        .ovf_out     (ovf),
        .data_out    (dout)
    );

    always #5 clk = ~clk;

    typedef struct {
        int s0; bit d0;
        int s1; bit d1;
        int s2; bit d2;
        int nb;
        int w0; int w1; int w2;
        int rise1;
        int done_last;
        int idle_at;
        int ovf_at;
    } vec_t;

    localparam int LEN = 800;
    localparam int NV  = 6;
    vec_t vecs [NV];

    logic sd [LEN];
    logic sb [LEN];
    logic sdn[LEN];
    logic so [LEN];

    task automatic chk(input string nm, input int act, input int exp);
        nchk++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        rdy = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_vec(input int id, input vec_t v, input bit rs);
        int rises[$];
        int widths[$];
        int run;
        int dcnt;
        int dlast;
        int idle;
        int ofirst;
        string p;
        if (rs) do_reset();
        for (int c = 0; c < LEN; c++) begin
            @(posedge clk);
            #1;
            rdy = 1'b0;
            din = 1'($urandom_range(0, 1));
            if (c == v.s0) begin rdy = 1'b1; din = v.d0; end
            if (c == v.s1) begin rdy = 1'b1; din = v.d1; end
            if (c == v.s2) begin rdy = 1'b1; din = v.d2; end
            sd[c]  = dout;
            sb[c]  = busy;
            sdn[c] = done;
            so[c]  = ovf;
        end
        rdy = 1'b0;
        run = 0; dcnt = 0; dlast = -1; idle = -1; ofirst = -1;
        for (int c = 0; c < LEN; c++) begin
            if (sd[c]) begin
                if (run == 0) rises.push_back(c);
                run++;
            end else if (run > 0) begin
                widths.push_back(run);
                run = 0;
            end
            if (sdn[c]) begin dcnt++; dlast = c; end
            if (idle < 0 && c > v.s0 + 1 && !sb[c]) idle = c;
            if (ofirst < 0 && so[c]) ofirst = c;
        end
        p = $sformatf("v%0d", id);
        chk({p, " nbits"}, rises.size(), v.nb);
        chk({p, " rise0"}, rises.size() > 0 ? rises[0] : -1, v.s0 + 1);
        chk({p, " busy_rise"}, {sb[v.s0], sb[v.s0 + 1]}, 1);
        chk({p, " w0"}, widths.size() > 0 ? widths[0] : -1, v.w0);
        if (v.nb > 1) begin
            chk({p, " rise1"}, rises.size() > 1 ? rises[1] : -1, v.rise1);
            chk({p, " w1"}, widths.size() > 1 ? widths[1] : -1, v.w1);
        end
        if (v.nb > 2)
            chk({p, " w2"}, widths.size() > 2 ? widths[2] : -1, v.w2);
        chk({p, " done_cnt"}, dcnt, v.nb);
        chk({p, " done_last"}, dlast, v.done_last);
        chk({p, " idle_at"}, idle, v.idle_at);
        chk({p, " ovf_at"}, ofirst, v.ovf_at);
        chk({p, " ovf_end"}, int'(so[LEN - 1]), int'(v.ovf_at >= 0));
    endtask

    localparam logic [23:0] PAT = 24'hA5C3F0;

    initial begin
        vec_t v1;
        int nxt, k, run, widx, dcnt;
        logic [23:0] pat;

        vecs[0] = '{10, 0, -1, 0, -1, 0, 1, 80, 0, 0, -1, 260, 261, -1};
        vecs[1] = '{10, 1, -1, 0, -1, 0, 1, 160, 0, 0, -1, 260, 261, -1};
        vecs[2] = '{10, 1, 20, 0, -1, 0, 2, 160, 80, 0, 261, 510, 511, -1};
        vecs[3] = '{10, 1, 20, 0, 30, 1, 2, 160, 80, 0, 261, 510, 511, 31};
        vecs[4] = '{10, 0, 260, 1, -1, 0, 2, 80, 160, 0, 261, 510, 511, -1};
        vecs[5] = '{10, 1, 20, 0, 260, 1, 3, 160, 80, 160, 261, 760, 761, -1};

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst data", int'(dout), 0);
        chk("rst busy", int'(busy), 0);
        chk("rst done", int'(done), 0);
        chk("rst ovf", int'(ovf), 0);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i], 1'b1);

        // reset during the 50th high cycle of a '1'
        do_reset();
        for (int c = 0; c <= 60; c++) begin
            @(posedge clk);
            #1;
            rdy = (c == 10);
            din = 1'b1;
        end
        chk("mid high", int'(dout), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst data", int'(dout), 0);
        chk("arst busy", int'(busy), 0);
        @(posedge clk);
        #1;
        chk("rst hold", int'({dout, busy, done, ovf}), 0);
        @(negedge clk);
        rst = 1'b0;
        v1 = vecs[1];
        run_vec(10, v1, 1'b0);

        // closed loop: controller strobes 2 cycles after each done
        do_reset();
        pat = PAT;
        nxt = 5; k = 0; run = 0; widx = 0; dcnt = 0;
        for (int c = 0; c < 7000; c++) begin
            @(posedge clk);
            #1;
            rdy = 1'b0;
            din = 1'($urandom_range(0, 1));
            if (c == nxt && k < 24) begin
                rdy = 1'b1;
                din = pat[23 - k];
                k++;
            end
            if (done) begin
                dcnt++;
                nxt = c + 2;
            end
            if (dout) begin
                run++;
            end else if (run > 0) begin
                if (widx < 24)
                    chk($sformatf("loop w%0d", widx), run,
                        pat[23 - widx] ? 160 : 80);
                widx++;
                run = 0;
            end
            if (dcnt == 24 && !busy) break;
        end
        rdy = 1'b0;
        chk("loop done_cnt", dcnt, 24);
        chk("loop bits", widx, 24);
        chk("loop ovf", int'(ovf), 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
